// File: rtl/vx_elastic_buffer.sv
// Elastic valid/ready buffer: passthrough, pipe register, skid buffer or FIFO with registered output.
// Optional occupancy output on `count` when VX_ELASTIC_BUFFER_COUNT_EN is defined.
module vx_elastic_buffer #(
    parameter int DATAW = 1,
    parameter int SIZE  = 2,
    parameter int CNTW  = (SIZE == 0) ? 1 : $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out,
    output logic [CNTW-1:0]  count
);

    if (SIZE == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, reset};
        assign valid_out = valid_in;
        assign data_out  = data_in;
        assign ready_in  = ready_out;
        assign count     = '0;

    end else if (SIZE == 1) begin : g_pipe
        logic             valid_q;
        logic [DATAW-1:0] data_q;

        assign ready_in  = !valid_q || ready_out;
        assign valid_out = valid_q;
        assign data_out  = data_q;

        always_ff @(posedge clk) begin
            if (reset)         valid_q <= 1'b0;
            else if (ready_in) valid_q <= valid_in;
        end

        always_ff @(posedge clk) begin
            if (ready_in) data_q <= data_in;
        end

`ifdef VX_ELASTIC_BUFFER_COUNT_EN
        assign count = CNTW'(valid_q);
`else
        assign count = '0;
`endif

    end else if (SIZE == 2) begin : g_skid
        logic             valid_q, skid_vld_q;
        logic [DATAW-1:0] data_q, skid_q;
        logic             push, out_free;

        // ready_in comes from a flop only, breaking the ready_out -> ready_in path
        assign ready_in  = !skid_vld_q;
        assign push      = valid_in && ready_in;
        assign out_free  = !valid_q || ready_out;
        assign valid_out = valid_q;
        assign data_out  = data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q    <= 1'b0;
                skid_vld_q <= 1'b0;
            end else if (out_free) begin
                valid_q    <= skid_vld_q || push;
                skid_vld_q <= 1'b0;
            end else if (push) begin
                skid_vld_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (out_free) begin
                if (skid_vld_q) data_q <= skid_q;
                else if (push)  data_q <= data_in;
            end else if (push) begin
                skid_q <= data_in;
            end
        end

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (!reset) assert (!(push && !out_free && skid_vld_q));
        end
`endif

`ifdef VX_ELASTIC_BUFFER_COUNT_EN
        assign count = CNTW'(valid_q) + CNTW'(skid_vld_q);
`else
        assign count = '0;
`endif

    end else begin : g_fifo
        localparam int DEPTH = SIZE - 1;
        localparam int AW    = $clog2(DEPTH);

        logic [DATAW-1:0] mem [DEPTH];
        logic [DATAW-1:0] data_q;
        logic             valid_q;
        logic [AW-1:0]    rd_q, wr_q;
        logic [CNTW-1:0]  cnt_q, cnt_d;
        logic             push, pop, out_free, store_empty, store_wr;

        assign ready_in    = cnt_q < CNTW'(SIZE);
        assign push        = valid_in && ready_in;
        assign pop         = valid_q && ready_out;
        assign out_free    = !valid_q || ready_out;
        // cnt_q counts the output register too; the store is empty when that is all it holds
        assign store_empty = (cnt_q == CNTW'(valid_q));
        assign store_wr    = push && !(out_free && store_empty);
        assign valid_out   = valid_q;
        assign data_out    = data_q;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
            else if (pop && !push) cnt_d = cnt_q - CNTW'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                rd_q    <= '0;
                wr_q    <= '0;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (out_free) begin
                    if (!store_empty) begin
                        valid_q <= 1'b1;
                        rd_q    <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
                    end else begin
                        valid_q <= push;
                    end
                end
                if (store_wr) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (out_free) begin
                if (!store_empty) data_q <= mem[rd_q];
                else if (push)    data_q <= data_in;
            end
            if (store_wr) mem[wr_q] <= data_in;
        end

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (!reset) assert (!(store_wr && (cnt_q - CNTW'(valid_q)) == CNTW'(DEPTH)));
        end
`endif

`ifdef VX_ELASTIC_BUFFER_COUNT_EN
        assign count = cnt_q;
`else
        assign count = '0;
`endif
    end

endmodule

// File: tb/tb_vx_elastic_buffer.sv
// Directed and random checks of vx_elastic_buffer across SIZE 0,1,2,5,3,4,7.
module tb_vx_elastic_buffer;

    localparam int NI = 7;

    function automatic int sz(int g);
        case (g)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 5;
            4: return 3;
            5: return 4;
            default: return 7;
        endcase
    endfunction

`ifdef VX_ELASTIC_BUFFER_COUNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] vin, rin, vout, rout;
    logic [7:0]    din  [NI];
    logic [7:0]    dout [NI];
    logic [3:0]    cnt  [NI];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int S  = sz(g);
        localparam int CW = (S == 0) ? 1 : $clog2(S + 1);
        logic [CW-1:0] c;
        vx_elastic_buffer #(.DATAW(8), .SIZE(S)) u_dut (
            .clk(clk), .reset(reset),
            .valid_in(vin[g]), .ready_in(rin[g]), .data_in(din[g]),
            .valid_out(vout[g]), .ready_out(rout[g]), .data_out(dout[g]),
            .count(c)
        );
        assign cnt[g] = 4'(c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vin  = '0;
        rout = '1;
        for (int g = 0; g < NI; g++) din[g] = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if (vout[g] !== 1'b0 || rin[g] !== 1'b1 || cnt[g] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset g=%0d got v=%b r=%b c=%0d exp v=0 r=1 c=0", g, vout[g], rin[g], cnt[g]);
            end
        end
    endtask

    task automatic test_passthrough();
        vin[0] = 1'b1; din[0] = 8'h5A; rout[0] = 1'b0;
        #1;
        n_cmp++;
        if (vout[0] !== 1'b1 || dout[0] !== 8'h5A || rin[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_stall got v=%b d=%h r=%b exp v=1 d=5a r=0", vout[0], dout[0], rin[0]);
        end
        rout[0] = 1'b1;
        #1;
        n_cmp++;
        if (rin[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_ready got r=%b exp 1", rin[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_skid();
        do_reset();
        rout[2] = 1'b0;
        vin[2] = 1'b1; din[2] = 8'h0A;
        tick();
        din[2] = 8'h0B;
        tick();
        vin[2] = 1'b0;
        n_cmp++;
        if (rin[2] !== 1'b0 || vout[2] !== 1'b1 || dout[2] !== 8'h0A || cnt[2] !== 4'(CEN ? 2 : 0)) begin
            n_fail++;
            $display("FAIL skid_full got r=%b v=%b d=%h c=%0d exp r=0 v=1 d=0a c=%0d",
                     rin[2], vout[2], dout[2], cnt[2], CEN ? 2 : 0);
        end
        tick();
        n_cmp++;
        if (vout[2] !== 1'b1 || dout[2] !== 8'h0A) begin
            n_fail++;
            $display("FAIL skid_hold got v=%b d=%h exp v=1 d=0a", vout[2], dout[2]);
        end
        rout[2] = 1'b1;
        tick();
        n_cmp++;
        if (vout[2] !== 1'b1 || dout[2] !== 8'h0B || rin[2] !== 1'b1 || cnt[2] !== 4'(CEN ? 1 : 0)) begin
            n_fail++;
            $display("FAIL skid_drain got v=%b d=%h r=%b c=%0d exp v=1 d=0b r=1", vout[2], dout[2], rin[2], cnt[2]);
        end
        tick();
        n_cmp++;
        if (vout[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_empty got v=%b exp 0", vout[2]);
        end
    endtask

    task automatic test_fifo();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            rout[3] = 1'b0;
            vin[3]  = 1'b1;
            for (int i = 1; i <= 5; i++) begin
                din[3] = 8'(pass * 5 + i);
                tick();
            end
            n_cmp++;
            if (rin[3] !== 1'b0 || vout[3] !== 1'b1 || dout[3] !== 8'(pass * 5 + 1) || cnt[3] !== 4'(CEN ? 5 : 0)) begin
                n_fail++;
                $display("FAIL fifo_full pass=%0d got r=%b v=%b d=%h c=%0d exp r=0 v=1 d=%h c=%0d",
                         pass, rin[3], vout[3], dout[3], cnt[3], 8'(pass * 5 + 1), CEN ? 5 : 0);
            end
            // full: a same-cycle pop must not admit the offered word
            din[3]  = 8'h66;
            rout[3] = 1'b1;
            tick();
            vin[3] = 1'b0;
            n_cmp++;
            if (cnt[3] !== 4'(CEN ? 4 : 0) || rin[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL fifo_full_pop pass=%0d got c=%0d r=%b exp c=%0d r=1", pass, cnt[3], rin[3], CEN ? 4 : 0);
            end
            for (int i = 2; i <= 5; i++) begin
                n_cmp++;
                if (vout[3] !== 1'b1 || dout[3] !== 8'(pass * 5 + i)) begin
                    n_fail++;
                    $display("FAIL fifo_drain pass=%0d got v=%b d=%h exp v=1 d=%h", pass, vout[3], dout[3], 8'(pass * 5 + i));
                end
                tick();
            end
            n_cmp++;
            if (vout[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL fifo_empty pass=%0d got v=%b exp 0", pass, vout[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vin[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            din[1] = 8'(k);
            tick();
            n_cmp++;
            if (vout[1] !== 1'b1 || dout[1] !== 8'(k) || rin[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL stream k=%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", k, vout[1], dout[1], rin[1], 8'(k));
            end
        end
        vin[1] = 1'b0;
        tick();
        n_cmp++;
        if (vout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end got v=%b exp 0", vout[1]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rout[3] = 1'b0;
        vin[3]  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din[3] = 8'(8'h20 + i);
            tick();
        end
        vin[3] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (vout[3] !== 1'b0 || rin[3] !== 1'b1 || cnt[3] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b r=%b c=%0d exp v=0 r=1 c=0", vout[3], rin[3], cnt[3]);
        end
        vin[3] = 1'b1; din[3] = 8'h07;
        tick();
        vin[3] = 1'b0; rout[3] = 1'b1;
        n_cmp++;
        if (vout[3] !== 1'b1 || dout[3] !== 8'h07) begin
            n_fail++;
            $display("FAIL mid_reset_first got v=%b d=%h exp v=1 d=07", vout[3], dout[3]);
        end
        tick();
        n_cmp++;
        if (vout[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_stale got v=%b d=%h exp v=0", vout[3], dout[3]);
        end
    endtask

    task automatic test_random();
        int         head [NI];
        int         tail [NI];
        int         seq  [NI];
        logic [7:0] model [NI][64];
        bit         held [NI];
        logic [7:0] held_d [NI];
        do_reset();
        for (int g = 0; g < NI; g++) begin
            head[g] = 0; tail[g] = 0; seq[g] = 0; held[g] = 1'b0; held_d[g] = 8'h00;
        end
        for (int cy = 0; cy < 10000; cy++) begin
            for (int g = 0; g < NI; g++) begin
                vin[g]  = 1'($urandom_range(0, 1));
                rout[g] = 1'($urandom_range(0, 1));
                din[g]  = 8'(seq[g]);
            end
            #1;
            for (int g = 0; g < NI; g++) begin
                int occ;
                occ = tail[g] - head[g];
                n_cmp++;
                if (cnt[g] !== 4'((CEN && g != 0) ? occ : 0) || occ > sz(g)) begin
                    n_fail++;
                    $display("FAIL rnd_count g=%0d cy=%0d got c=%0d occ=%0d exp c=%0d", g, cy, cnt[g], occ,
                             (CEN && g != 0) ? occ : 0);
                end
                if (g != 0 && held[g]) begin
                    n_cmp++;
                    if (vout[g] !== 1'b1 || dout[g] !== held_d[g]) begin
                        n_fail++;
                        $display("FAIL rnd_stable g=%0d cy=%0d got v=%b d=%h exp v=1 d=%h", g, cy, vout[g], dout[g], held_d[g]);
                    end
                end
                if (vin[g] && rin[g]) begin
                    model[g][tail[g] % 64] = din[g];
                    tail[g]++;
                    seq[g]++;
                end
                if (vout[g] && rout[g]) begin
                    n_cmp++;
                    if (head[g] == tail[g] || dout[g] !== model[g][head[g] % 64]) begin
                        n_fail++;
                        $display("FAIL rnd_order g=%0d cy=%0d got d=%h exp d=%h held=%0d", g, cy, dout[g],
                                 model[g][head[g] % 64], tail[g] - head[g]);
                    end
                    if (head[g] != tail[g]) head[g]++;
                end
                held[g]   = vout[g] && !rout[g];
                held_d[g] = dout[g];
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_passthrough();
        test_skid();
        test_fifo();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_elastic_buffer.md
# vx_elastic_buffer

Parametrised elastic buffer for valid/ready pipeline stages: one module covering passthrough, single pipe register, two-entry skid buffer and N-entry FIFO with registered output. Used at stage boundaries (issue, LSU, cache request/response) wherever timing isolation or decoupling depth is needed. It makes the buffer depth a tunable parameter instead of a fixed structure, and it can optionally report occupancy.

## Interface
- DATAW, 1, payload width in bits (≥1)
- SIZE, 2, total storage entries including the output register; 0 = passthrough, 1 = pipe register, 2 = skid buffer, ≥3 = FIFO
- CNTW, $clog2(SIZE+1) (min 1), width of `count`; derived, must not be overridden

- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- valid_in  input  1  upstream payload valid
- ready_in  output  1  buffer can accept this cycle
- data_in  input  DATAW  upstream payload
- valid_out  output  1  downstream payload valid
- ready_out  input  1  downstream accepts this cycle
- data_out  output  DATAW  downstream payload
- count  output  CNTW  entries held (see Configuration)

## Operation
- push = valid_in && ready_in; pop = valid_out && ready_out.
- Strict FIFO order, no drop, no duplication, in every mode.
- SIZE=0: combinational wires valid_out=valid_in, data_out=data_in, ready_in=ready_out. clk/reset unused. count=0.
- SIZE=1: one register. ready_in = !valid_out || ready_out (combinational). This gives full throughput. The register loads data_in whenever ready_in is high.
- SIZE=2: output register plus one skid entry. ready_in = !skid_full (registered; no combinational ready_out→ready_in path).
  - A push while the output is held stalled loads the skid entry.
  - When ready_out is high, the skid entry, if occupied, moves to the output before new data.
- SIZE≥3: output register plus circular store of SIZE-1 entries. Read/write pointers wrap from SIZE-2 to 0; SIZE need not be a power of two.
  - ready_in = (occupancy < SIZE), registered. A same-cycle pop does not free a slot for a same-cycle push when the buffer is full.
  - Bypass: when the store is empty and the output register is empty or popping, a push loads the output register directly.
  - Otherwise a push is written into the store. When the output register is empty or popping, it refills from the store head.
- Occupancy: push-only +1, pop-only −1, push and pop together unchanged. Never exceeds SIZE and never underflows.
- Data registers are not reset. data_out is meaningful only when valid_out=1.

## Timing
- Reset values: valid_out=0, ready_in=1 (all SIZE≥1), count=0. Pointers and occupancy are cleared.
- Reset mid-operation discards all contents in the same edge.
- Latency: SIZE≥1 gives 1 cycle from push to valid_out when the buffer is empty (including FIFO bypass).
- Throughput: 1 transfer/cycle sustained in every mode when ready_out=1.
- Stability: while valid_out && !ready_out, valid_out and data_out hold unchanged.
- ready_in for SIZE≥2 depends only on registered state.
- A push while ready_in=0 is ignored, and data_in is not captured.
- SIMULATION-only assertion: the skid or FIFO store never overflows.

## Configuration
- VX_ELASTIC_BUFFER_COUNT_EN: when defined, a CNTW-bit occupancy counter drives `count`. The counter equals entries held, including the output register, updated per the Operation rules.
- When the macro is undefined, `count` is tied to 0 and the counter logic is removed. Only modes that need the counter internally (SIZE≥3) keep it, without exposing it.
- Data path, handshake and timing are identical either way.

## Test plan
- SIZE=2, ready_out=0, push 0xA then 0xB → ready_in=0 after 2nd push, data_out=0xA held. Raise ready_out → out 0xA, 0xB in order, ready_in=1 the cycle after the skid entry drains.
- SIZE=5, ready_out=0, push 5 words 1..5 → ready_in=0, count=5 (COUNT_EN). Pop all → data 1..5, pointers wrap correctly on a second fill of 6..10.
- SIZE=5, full, same-cycle valid_in and ready_out → pop occurs, push rejected, count=4.
- SIZE=1, ready_out=1, valid_in continuous 100 words → 100 outputs, 1/cycle, 1-cycle latency.
- Any SIZE, buffer holding 3 words, assert reset 1 cycle → next cycle valid_out=0, ready_in=1, count=0. Subsequent push of 0x7 appears as first output.
- Random valid_in/ready_out (50%), SIZE∈{0,1,2,3,4,7}, 10k cycles → scoreboard order match, stability rule never violated, no overflow assertion.
